// File: rtl/acia_host.sv
// Host-side sequencer for a 6850-style ACIA: master reset, control init, then
// a polled status loop that moves bytes between the ACIA and two ready/valid ports.
module acia_host #(
   parameter logic [7:0] CTRL_INIT = 8'h96,
   parameter int          POLL_GAP  = 4,
   parameter bit          USE_IRQ   = 1'b0
) (
   input  logic       CLK,
   input  logic       nRESET,
   output logic       E,
   output logic [2:0] CS,
   output logic       RS,
   output logic       RnW,
   output logic [7:0] DO,
   input  logic [7:0] DI,
   input  logic       nIRQ,
   input  logic [7:0] txData,
   input  logic       txValid,
   output logic       txReady,
   output logic [7:0] rxData,
   output logic       rxFE,
   output logic       rxValid,
   input  logic       rxReady,
   output logic       errOVR,
   input  logic       errClr,
   output logic       initDone
);

   typedef enum logic [3:0] {
      MRST, MRST_GAP, INIT, GAP, IDLE, STAT_RD, STAT_CAP,
      DECIDE, RDR_RD, RDR_CAP, TDR_WR
   } state_t;

   localparam logic [7:0] GAP_LAST = 8'(POLL_GAP - 1);

   state_t     state, state_next;
   logic       run;
   logic [7:0] gap_cnt;
   logic       stat_rdrf, stat_tdre, stat_fe;
   logic [7:0] tx_byte;
   logic       take_rx, take_tx;

   // Receive has priority, but only when the previous byte has been consumed.
   assign take_rx = stat_rdrf && !rxValid;
   assign take_tx = !take_rx && stat_tdre && txValid;

   // run holds MRST silent during reset so the first strobe lands after the first edge.
   // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         state <= MRST;
         run   <= 1'b0;
      end else begin
         state <= state_next;
         run   <= 1'b1;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         MRST:     state_next = run ? MRST_GAP : MRST;
         MRST_GAP: state_next = INIT;
         INIT:     state_next = GAP;
         GAP:      if (gap_cnt == GAP_LAST) state_next = IDLE;
         IDLE:     if (!USE_IRQ || !nIRQ || txValid) state_next = STAT_RD;
         STAT_RD:  state_next = STAT_CAP;
         STAT_CAP: state_next = DECIDE;
         DECIDE:   state_next = take_rx ? RDR_RD : (take_tx ? TDR_WR : GAP);
         RDR_RD:   state_next = RDR_CAP;
         RDR_CAP:  state_next = GAP;
         TDR_WR:   state_next = GAP;
         default:  state_next = MRST;
      endcase
   end

   // NOTE: every output gets a default before the case so no latches are inferred.
   always_comb begin
      E       = 1'b0;
      RS      = 1'b0;
      RnW     = 1'b1;
      DO      = 8'h00;
      txReady = 1'b0;
      case (state)
         MRST: if (run) begin
            E   = 1'b1;
            RnW = 1'b0;
            DO  = 8'h03;
         end
         INIT: begin
            E   = 1'b1;
            RnW = 1'b0;
            DO  = CTRL_INIT;
         end
         STAT_RD: E = 1'b1;
         DECIDE:  txReady = take_tx;
         RDR_RD: begin
            E  = 1'b1;
            RS = 1'b1;
         end
         TDR_WR: begin
            E   = 1'b1;
            RS  = 1'b1;
            RnW = 1'b0;
            DO  = tx_byte;
         end
         default: ;
      endcase
      CS = E ? 3'b011 : 3'b000;
   end

   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) gap_cnt <= 8'd0;
      else if (state == GAP) gap_cnt <= gap_cnt + 8'd1;
      else gap_cnt <= 8'd0;
   end

   // NOTE: data registers are reset too, so outputs never show X after reset.
   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         stat_rdrf <= 1'b0;
         stat_tdre <= 1'b0;
         stat_fe   <= 1'b0;
         tx_byte   <= 8'h00;
         rxData    <= 8'h00;
         rxFE      <= 1'b0;
         rxValid   <= 1'b0;
         errOVR    <= 1'b0;
         initDone  <= 1'b0;
      end else begin
         if (state == STAT_CAP) begin
            stat_rdrf <= DI[0];
            stat_tdre <= DI[1];
            stat_fe   <= DI[4];
         end
         if (txReady) tx_byte <= txData;
         if (state == RDR_CAP) begin
            rxData  <= DI;
            rxFE    <= stat_fe;
            rxValid <= 1'b1;
         end else if (rxValid && rxReady) begin
            rxValid <= 1'b0;
         end
         // A fresh overrun outranks a simultaneous clear.
         if (state == STAT_CAP && DI[5]) errOVR <= 1'b1;
         else if (errClr) errOVR <= 1'b0;
         if (state == INIT) initDone <= 1'b1;
      end
   end

endmodule

// File: tb/tb_acia_host.sv
// Bench for acia_host: ACIA behaviour is emulated at the bus, and each poll is
// predicted from a transaction-level model of the decide/handshake rules.
module tb_acia_host;

   localparam int PG = 4;

   logic       CLK = 1'b0;
   logic       nRESET = 1'b0, nRESET2 = 1'b0;
   logic [7:0] DI = 8'h00, txData = 8'h00;
   logic       nIRQ = 1'b1, nIRQ2 = 1'b1;
   logic       txValid = 1'b0, txValid2 = 1'b0;
   logic       rxReady = 1'b0, errClr = 1'b0;

   logic       E, RS, RnW, txReady, rxFE, rxValid, errOVR, initDone;
   logic [2:0] CS;
   logic [7:0] DO, rxData;

   logic       e2, rs2, rnw2, txready2, rxfe2, rxvalid2, errovr2, initdone2;
   logic [2:0] cs2;
   logic [7:0] do2, rxdata2;

   acia_host #(.CTRL_INIT(8'h96), .POLL_GAP(PG), .USE_IRQ(1'b0)) dut (
      .CLK(CLK), .nRESET(nRESET), .E(E), .CS(CS), .RS(RS), .RnW(RnW), .DO(DO),
      .DI(DI), .nIRQ(nIRQ), .txData(txData), .txValid(txValid), .txReady(txReady),
      .rxData(rxData), .rxFE(rxFE), .rxValid(rxValid), .rxReady(rxReady),
      .errOVR(errOVR), .errClr(errClr), .initDone(initDone)
   );

   acia_host #(.CTRL_INIT(8'h96), .POLL_GAP(PG), .USE_IRQ(1'b1)) dut_irq (
      .CLK(CLK), .nRESET(nRESET2), .E(e2), .CS(cs2), .RS(rs2), .RnW(rnw2), .DO(do2),
      .DI(DI), .nIRQ(nIRQ2), .txData(txData), .txValid(txValid2), .txReady(txready2),
      .rxData(rxdata2), .rxFE(rxfe2), .rxValid(rxvalid2), .rxReady(rxReady),
      .errOVR(errovr2), .errClr(errClr), .initDone(initdone2)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
      end
   endtask

   // No access strobe may follow another directly, on either instance.
   logic prev_e = 1'b0, prev_e2 = 1'b0;
   bit   mon_en = 1'b0;
   always @(negedge CLK) begin
      if (mon_en) begin
         check("e_spacing", 32'(E & prev_e), 0);
         check("e2_spacing", 32'(e2 & prev_e2), 0);
      end
      prev_e  <= E;
      prev_e2 <= e2;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // Model state: pending received byte, sticky overrun, expected poll latency.
   bit         rx_pend = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_fe = 1'b0;
   logic       ovr_m = 1'b0;
   int         nw = 0;

   task automatic wait_access(output int cyc);
      cyc = 0;
      do begin
         @(negedge CLK);
         cyc++;
      end while (!E && cyc < 300);
      check("access_seen", 32'(E), 1);
      check("cs_on_e", 32'(CS), 3);
   endtask

   task automatic check_reset_state();
      check("rst_e", 32'(E), 0);
      check("rst_cs", 32'(CS), 0);
      check("rst_rs", 32'(RS), 0);
      check("rst_rnw", 32'(RnW), 1);
      check("rst_do", 32'(DO), 0);
      check("rst_txready", 32'(txReady), 0);
      check("rst_rxvalid", 32'(rxValid), 0);
      check("rst_rxdata", 32'(rxData), 0);
      check("rst_rxfe", 32'(rxFE), 0);
      check("rst_errovr", 32'(errOVR), 0);
      check("rst_initdone", 32'(initDone), 0);
   endtask

   task automatic release_init();
      @(negedge CLK);
      nRESET = 1'b1;
      @(negedge CLK);
      check("mrst_e", 32'(E), 1);
      check("mrst_do", 32'(DO), 'h03);
      check("mrst_rs", 32'(RS), 0);
      check("mrst_rnw", 32'(RnW), 0);
      @(negedge CLK);
      check("mrst_gap_e", 32'(E), 0);
      @(negedge CLK);
      check("init_e", 32'(E), 1);
      check("init_do", 32'(DO), 'h96);
      check("init_rnw", 32'(RnW), 0);
      check("init_done_early", 32'(initDone), 0);
      @(negedge CLK);
      check("init_done", 32'(initDone), 1);
      check("init_gap_e", 32'(E), 0);
      nw      = PG + 1;
      rx_pend = 1'b0;
      ovr_m   = 1'b0;
   endtask

   // One poll: answer the status read, then follow the expected branch
   // (kind 0 = back to gap, 1 = RDR read, 2 = TDR write).
   task automatic run_poll(input logic [7:0] st, input logic txv, input logic [7:0] txd,
                           input logic [7:0] rdr, input logic ready, input logic clr,
                           input int kind, input logic txr, input logic ovr);
      int cyc;
      check("rx_valid_pre", 32'(rxValid), 32'(rx_pend));
      if (ready && rx_pend) begin
         check("rx_data", 32'(rxData), 32'(rx_data));
         check("rx_fe", 32'(rxFE), 32'(rx_fe));
      end
      wait_access(cyc);
      check("stat_latency", 32'(cyc), 32'(nw));
      check("stat_rs", 32'(RS), 0);
      check("stat_rnw", 32'(RnW), 1);
      check("stat_do", 32'(DO), 0);
      DI      = st;
      txValid = txv;
      txData  = txd;
      rxReady = ready;
      @(negedge CLK);
      rxReady = 1'b0;
      errClr  = clr;
      if (ready) check("rx_valid_clr", 32'(rxValid), 0);
      @(negedge CLK);
      errClr = 1'b0;
      check("tx_ready", 32'(txReady), 32'(txr));
      check("err_ovr", 32'(errOVR), 32'(ovr));
      if (ready) rx_pend = 1'b0;
      ovr_m = ovr;
      if (kind == 1) begin
         wait_access(cyc);
         check("rdr_latency", 32'(cyc), 1);
         check("rdr_rs", 32'(RS), 1);
         check("rdr_rnw", 32'(RnW), 1);
         DI = rdr;
         repeat (2) @(negedge CLK);
         rx_pend = 1'b1;
         rx_data = rdr;
         rx_fe   = st[4];
         check("rx_cap_valid", 32'(rxValid), 1);
         check("rx_cap_data", 32'(rxData), 32'(rdr));
         check("rx_cap_fe", 32'(rxFE), 32'(st[4]));
         nw = PG + 1;
      end else if (kind == 2) begin
         wait_access(cyc);
         check("tdr_latency", 32'(cyc), 1);
         check("tdr_rs", 32'(RS), 1);
         check("tdr_rnw", 32'(RnW), 0);
         check("tdr_do", 32'(DO), 32'(txd));
         txValid = 1'b0;
         nw = PG + 2;
      end else begin
         nw = PG + 2;
      end
   endtask

   typedef struct {
      logic [7:0] st;
      logic       txv;
      logic [7:0] txd;
      logic [7:0] rdr;
      logic       ready;
      logic       clr;
      int         kind;
      logic       txr;
      logic       ovr;
   } vec_t;

   vec_t tbl[11];

   initial begin
      tbl[0]  = '{8'h02, 1'b1, 8'h41, 8'h00, 1'b0, 1'b0, 2, 1'b1, 1'b0};
      tbl[1]  = '{8'h03, 1'b1, 8'h42, 8'h5A, 1'b0, 1'b0, 1, 1'b0, 1'b0};
      tbl[2]  = '{8'h21, 1'b0, 8'h42, 8'h00, 1'b0, 1'b0, 0, 1'b0, 1'b1};
      tbl[3]  = '{8'h03, 1'b1, 8'h77, 8'h00, 1'b0, 1'b0, 2, 1'b1, 1'b1};
      tbl[4]  = '{8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b0};
      tbl[5]  = '{8'h20, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b1};
      tbl[6]  = '{8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b0};
      tbl[7]  = '{8'h13, 1'b1, 8'h99, 8'hC3, 1'b1, 1'b0, 1, 1'b0, 1'b0};
      tbl[8]  = '{8'h01, 1'b1, 8'h99, 8'h00, 1'b0, 1'b0, 0, 1'b0, 1'b0};
      tbl[9]  = '{8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b0};
      tbl[10] = '{8'h01, 1'b0, 8'h00, 8'h3C, 1'b0, 1'b0, 1, 1'b0, 1'b0};

      repeat (3) @(negedge CLK);
      check_reset_state();
      mon_en = 1'b1;
      release_init();

      for (int i = 0; i < 11; i++)
         run_poll(tbl[i].st, tbl[i].txv, tbl[i].txd, tbl[i].rdr, tbl[i].ready,
                  tbl[i].clr, tbl[i].kind, tbl[i].txr, tbl[i].ovr);

      for (int i = 0; i < 60; i++) begin
         logic [7:0] st, txd, rdr;
         logic       txv, ready, clr, ovr;
         int         kind;
         st    = 8'($urandom);
         st[5] = ($urandom_range(0, 5) == 0);
         txv   = 1'($urandom);
         txd   = 8'($urandom);
         rdr   = 8'($urandom);
         ready = 1'($urandom);
         clr   = ($urandom_range(0, 3) == 0);
         if (st[0] && !(rx_pend && !ready)) kind = 1;
         else if (st[1] && txv) kind = 2;
         else kind = 0;
         ovr = st[5] ? 1'b1 : (clr ? 1'b0 : ovr_m);
         run_poll(st, txv, txd, rdr, ready, clr, kind, (kind == 2), ovr);
      end

      // Reset lands during the TDR write strobe.
      run_poll(8'h02, 1'b1, 8'hAA, 8'h00, 1'b0, 1'b0, 2, 1'b1, ovr_m);
      nRESET  = 1'b0;
      #1;
      check_reset_state();
      txValid = 1'b0;
      DI      = 8'h00;
      release_init();
      run_poll(8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 0, 1'b0, 1'b0);

      // Interrupt-driven instance: idle until nIRQ or txValid.
      begin
         int pulses;
         nRESET = 1'b0;
         DI     = 8'h00;
         @(negedge CLK);
         nRESET2 = 1'b1;
         pulses  = 0;
         repeat (40) begin
            @(negedge CLK);
            if (e2) pulses++;
         end
         check("irq_init_pulses", 32'(pulses), 2);
         check("irq_initdone", 32'(initdone2), 1);
         nIRQ2 = 1'b0;
         @(negedge CLK);
         check("irq_wake_e", 32'(e2), 1);
         check("irq_wake_rs", 32'(rs2), 0);
         check("irq_wake_rnw", 32'(rnw2), 1);
         nIRQ2  = 1'b1;
         pulses = 0;
         repeat (20) begin
            @(negedge CLK);
            if (e2) pulses++;
         end
         check("irq_quiet_after", 32'(pulses), 0);
         txValid2 = 1'b1;
         @(negedge CLK);
         check("txv_wake_e", 32'(e2), 1);
         txValid2 = 1'b0;
         repeat (3) @(negedge CLK);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
